tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter W, default 26: width of the divide value and the phase counter.
REQ-002 Parameter DEFAULT_DIV, default 26'd49999999: divide value loaded at reset.
REQ-003 Parameter TW, default 16: width of tick_cnt.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level; begin generation when IDLE.
REQ-007 stop  input  1  level; request clean shutdown when running.
REQ-008 cfg_valid  input  1  new divide value offered.
REQ-009 cfg_div  input  W  offered divide value; half-period = cfg_div+1 cycles.
REQ-010 cfg_ready  output  1  config accepted on a cycle with cfg_valid&&cfg_ready.
REQ-011 busy  output  1  high in RUN or UPDATE.
REQ-012 tick  output  1  one-cycle pulse at each terminal count.
REQ-013 clk_out  output  1  divided square wave; toggles with each tick.
REQ-014 tick_cnt  output  TW  count of ticks since reset; wraps from all-ones to 0.

Function
REQ-015 FSM states IDLE, RUN, UPDATE; the FSM leaves IDLE only on start.
REQ-016 IDLE: cfg_ready=1; an accepted cfg_div loads div_active on the next edge; q held 0; tick=0; clk_out=0.
REQ-017 IDLE with start=1 and stop=0: next state RUN, q=0; start together with stop keeps IDLE.
REQ-018 RUN/UPDATE: q increments each cycle; when q==div_active, q<=0, tick=1 for that cycle, clk_out toggles, and tick_cnt increments modulo 2^TW.
REQ-019 div_active=0: tick every cycle, clk_out = clk_in/2.
REQ-020 First tick occurs div_active+1 cycles after RUN entry; period of clk_out = 2*(div_active+1) cycles.
REQ-021 RUN: cfg_ready=1; an accepted value goes to div_pending, next state UPDATE.
REQ-022 UPDATE: cfg_ready=0; counting continues on the old div_active; at terminal count, div_active<=div_pending, next state RUN.
REQ-023 A new value never alters a half-period in progress; no clk_out half-period is shorter than min(old,new)+1 cycles.
REQ-024 start while busy: ignored.
REQ-025 stop while busy sets stop_pend; stop_pend clears only on return to IDLE.
REQ-026 With stop_pend, at a terminal count with clk_out=1: clk_out<=0, tick=1, go IDLE, q=0; any pending config is applied to div_active on the same edge.
REQ-027 With stop_pend, at a terminal count with clk_out=0: normal toggle, and generation continues; the block never ends with clk_out high.
REQ-028 cfg_valid without cfg_ready: no effect; the offerer holds cfg_valid until the handshake completes.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, q=0, div_active=DEFAULT_DIV, div_pending=DEFAULT_DIV, stop_pend=0, clk_out=0, tick=0, tick_cnt=0.
REQ-030 Reset mid-operation aborts immediately; no tick is emitted; release requires a fresh start.
REQ-031 Reset release is synchronised externally; the block adds no synchroniser.

Structure
REQ-032 Package tick_sched_pkg holds the state enum (IDLE, RUN, UPDATE) and default W/TW constants.
REQ-033 Single module; no sub-module.
REQ-034 All outputs registered, except cfg_ready and busy, which are decoded from state.

Verification (DEFAULT_DIV=3, W=8, TW=4)
REQ-035 Reset, start pulse -> tick on 4th RUN cycle, then every 4 cycles; clk_out period 8 cycles.
REQ-036 In RUN at q=1, cfg_div=1 -> cfg_ready drops; the current half-period stays 4 cycles; after it, 2-cycle half-periods; RUN resumes.
REQ-037 stop asserted just after clk_out rises -> one more 4-cycle high phase, clk_out falls, busy drops, q=0.
REQ-038 stop asserted while clk_out low -> full low+high phase, then IDLE with clk_out=0.
REQ-039 cfg_div=0 in IDLE then start -> tick every cycle; 16 ticks wrap tick_cnt to 0.
REQ-040 rst_n low mid-phase with pending config -> all outputs to reset values in the same cycle; div_active=3 after release.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared types and default widths for the tick scheduler.
package tick_sched_pkg;

    // Control states: idle, counting, counting with a new divide value queued.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2
    } sched_state_t;

    localparam int SCHED_W  = 26;
    localparam int SCHED_TW = 16;

endpackage

// File: rtl/tick_scheduler.sv
// Programmable clock divider: emits a one-cycle tick and toggles clk_out every
// div_active+1 cycles. A new divide value takes effect only at a terminal count,
// and a stop request waits until clk_out is high at a terminal count so the
// output always finishes on a complete low/high period.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int             W           = SCHED_W,
    parameter logic [W-1:0]   DEFAULT_DIV = 26'd49999999,
    parameter int             TW          = SCHED_TW
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          cfg_valid,
    input  logic [W-1:0]  cfg_div,
    output logic          cfg_ready,
    output logic          busy,
    output logic          tick,
    output logic          clk_out,
    output logic [TW-1:0] tick_cnt
);

    sched_state_t  state_q, state_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  div_active_q, div_active_d;
    logic [W-1:0]  div_pending_q, div_pending_d;
    logic          stop_pend_q, stop_pend_d;
    logic          clk_out_q, clk_out_d;
    logic          tick_q, tick_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          cfg_fire;
    logic          terminal;

    assign busy      = (state_q != IDLE);
    assign cfg_ready = (state_q != UPDATE);
    assign tick      = tick_q;
    assign clk_out   = clk_out_q;
    assign tick_cnt  = tick_cnt_q;

    // Next-state and datapath update; tick is precomputed so it is high during the terminal cycle itself.
    always_comb begin
        state_d       = state_q;
        q_d           = q_q;
        div_active_d  = div_active_q;
        div_pending_d = div_pending_q;
        stop_pend_d   = stop_pend_q;
        clk_out_d     = clk_out_q;
        tick_cnt_d    = tick_cnt_q;
        cfg_fire      = cfg_valid && cfg_ready;
        terminal      = busy && (q_q == div_active_q);

        case (state_q)
            IDLE: begin
                q_d         = '0;
                clk_out_d   = 1'b0;
                stop_pend_d = 1'b0;
                if (cfg_fire) begin
                    div_active_d = cfg_div;
                end
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN, UPDATE: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (state_q == RUN && cfg_fire) begin
                    div_pending_d = cfg_div;
                    state_d       = UPDATE;
                end
                if (terminal) begin
                    q_d        = '0;
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (state_q == UPDATE) begin
                        div_active_d = div_pending_q;
                        state_d      = RUN;
                    end
                    if (stop_pend_q && clk_out_q) begin
                        // A value accepted on this very edge would otherwise be lost on the way to IDLE.
                        if (state_q == RUN && cfg_fire) begin
                            div_active_d = cfg_div;
                        end
                        clk_out_d   = 1'b0;
                        stop_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        clk_out_d = !clk_out_q;
                    end
                end else begin
                    q_d = q_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tick_d = (state_d != IDLE) && (q_d == div_active_d);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            q_q           <= '0;
            div_active_q  <= DEFAULT_DIV;
            div_pending_q <= DEFAULT_DIV;
            stop_pend_q   <= 1'b0;
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
            tick_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            q_q           <= q_d;
            div_active_q  <= div_active_d;
            div_pending_q <= div_pending_d;
            stop_pend_q   <= stop_pend_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            tick_cnt_q    <= tick_cnt_d;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler with W=8, TW=4, DEFAULT_DIV=3.
module tb_tick_scheduler;

    logic       clk_in;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       busy;
    logic       tick;
    logic       clk_out;
    logic [3:0] tick_cnt;

    typedef struct packed {
        logic       tick;
        logic       clk_out;
        logic       busy;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    exp_t o;
    int   n_compared;
    int   n_mismatched;

    tick_scheduler #(
        .W          (8),
        .DEFAULT_DIV(8'd3),
        .TW         (4)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .busy     (busy),
        .tick     (tick),
        .clk_out  (clk_out),
        .tick_cnt (tick_cnt)
    );

    // Free-running 10-unit clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Advance to just after the next rising edge, where outputs are sampled and inputs driven.
    task automatic cyc1();
        @(posedge clk_in);
        #1;
    endtask

    // Reset pulse released between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        cyc1();
    endtask

    // One-cycle start pulse; returns while sampling the first RUN cycle.
    task automatic start_run();
        start = 1'b1;
        cyc1();
        start = 1'b0;
    endtask

    // Expected per-cycle outputs for a run of half-periods: each half-period ends with a
    // tick, clk_out alternates per half-period starting low, and tick_cnt counts completed ones.
    task automatic push_halves(input int first_len, input int rest_len, input int n_rest,
                               input int k0, input int idle_tail);
        int len;
        exp_t x;
        for (int k = 0; k <= n_rest; k++) begin
            len = (k == 0) ? first_len : rest_len;
            for (int c = 1; c <= len; c++) begin
                x.tick    = (c == len);
                x.clk_out = ((k0 + k) % 2) == 1;
                x.busy    = 1'b1;
                x.cnt     = 4'((k0 + k) % 16);
                sb.push_back(x);
            end
        end
        for (int t = 0; t < idle_tail; t++) begin
            x.tick    = 1'b0;
            x.clk_out = 1'b0;
            x.busy    = 1'b0;
            x.cnt     = 4'((k0 + n_rest + 1) % 16);
            sb.push_back(x);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        o = {tick, clk_out, busy, tick_cnt};
        n_compared++;
        if (o !== 7'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got %b required %b", o, 7'b0);
        end
        n_compared++;
        if (cfg_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_cfg_ready: got %b required 1", cfg_ready);
        end
        rst_n = 1'b1;
        cyc1();
    endtask

    task automatic test_basic_run();
        do_reset();
        start_run();
        push_halves(4, 4, 4, 0, 0);
        for (int i = 1; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = {tick, clk_out, busy, tick_cnt};
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL basic_run cyc %0d: got %b required %b", i, o, e);
            end
            cyc1();
        end
    endtask

    task automatic test_cfg_update();
        do_reset();
        start_run();
        push_halves(4, 2, 4, 0, 0);
        for (int i = 1; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = {tick, clk_out, busy, tick_cnt};
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL cfg_update cyc %0d: got %b required %b", i, o, e);
            end
            if (i == 3 || i == 5) begin
                n_compared++;
                if (cfg_ready !== (i == 5)) begin
                    n_mismatched++;
                    $display("[TB] FAIL cfg_ready cyc %0d: got %b required %b", i, cfg_ready, i == 5);
                end
            end
            cfg_valid = (i == 2);
            cfg_div   = 8'd1;
            cyc1();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_stop_high();
        do_reset();
        start_run();
        push_halves(4, 4, 1, 0, 2);
        for (int i = 1; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = {tick, clk_out, busy, tick_cnt};
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL stop_high cyc %0d: got %b required %b", i, o, e);
            end
            stop = (i == 5);
            cyc1();
        end
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        start_run();
        push_halves(4, 4, 2, 2, 0);
        for (int i = 1; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = {tick, clk_out, busy, tick_cnt};
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL back_to_back cyc %0d: got %b required %b", i, o, e);
            end
            cyc1();
        end
    endtask

    task automatic test_stop_low();
        do_reset();
        start_run();
        push_halves(4, 4, 1, 0, 2);
        for (int i = 1; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = {tick, clk_out, busy, tick_cnt};
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL stop_low cyc %0d: got %b required %b", i, o, e);
            end
            stop = (i == 2);
            cyc1();
        end
        stop = 1'b0;
    endtask

    task automatic test_start_with_stop();
        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc1();
            n_compared++;
            if (busy !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL start_with_stop cyc %0d: got busy %b required 0", i, busy);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_div0_wrap();
        do_reset();
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        n_compared++;
        if (cfg_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL idle_cfg_ready: got %b required 1", cfg_ready);
        end
        cyc1();
        cfg_valid = 1'b0;
        start_run();
        push_halves(1, 1, 19, 0, 0);
        for (int i = 1; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = {tick, clk_out, busy, tick_cnt};
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL div0_wrap cyc %0d: got %b required %b", i, o, e);
            end
            cyc1();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_run();
        push_halves(4, 4, 1, 0, 0);
        for (int i = 1; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = {tick, clk_out, busy, tick_cnt};
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL reset_mid_pre cyc %0d: got %b required %b", i, o, e);
            end
            if (i == 7) begin
                rst_n = 1'b0;
                #1;
                o = {tick, clk_out, busy, tick_cnt};
                n_compared++;
                if (o !== 7'b0 || cfg_ready !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL reset_mid_abort: got %b rdy %b required %b rdy 1",
                             o, cfg_ready, 7'b0);
                end
                sb.delete();
                break;
            end
            cfg_valid = (i == 6);
            cfg_div   = 8'd1;
            cyc1();
        end
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc1();
        start_run();
        push_halves(4, 4, 1, 0, 0);
        for (int i = 1; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = {tick, clk_out, busy, tick_cnt};
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL reset_mid_post cyc %0d: got %b required %b", i, o, e);
            end
            cyc1();
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        cfg_valid    = 1'b0;
        cfg_div      = 8'd0;
        #1;
        test_reset();
        test_basic_run();
        test_cfg_update();
        test_stop_high();
        test_back_to_back();
        test_stop_low();
        test_start_with_stop();
        test_div0_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
